// File: rtl/line_d_cache.sv
// Single-line (64 B) write-back, write-allocate data cache. It serves 64-bit loads and
// stores from the resident line, and refills or writes back the whole line as 8-beat bursts.
module line_d_cache #(
    parameter logic [7:0] TAG_ID = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic        dbus_reqcyc,
    output logic [63:0] dbus_req,
    output logic [12:0] dbus_reqtag,
    input  logic        dbus_reqack,
    input  logic        dbus_respcyc,
    input  logic [63:0] dbus_resp,
    output logic        dbus_respack,
    input  logic [1:0]  req_cmd,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    output logic        respcyc,
    output logic [63:0] resp_data
);

    localparam logic [1:0]  CMD_READ  = 2'd1;
    localparam logic [1:0]  CMD_WRITE = 2'd2;
    localparam logic [12:0] TAG_RD    = {1'b1, 4'b0001, TAG_ID};
    localparam logic [12:0] TAG_WR    = {1'b0, 4'b0001, TAG_ID};

    typedef enum logic [2:0] {
        IDLE,
        HIT_RESP,
        WB_ADDR,
        WB_DATA,
        FILL_ADDR,
        FILL_DATA
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  beat_reg, beat_next;
    logic [57:0] tag_reg;
    logic        valid_reg;
    logic        dirty_reg;
    logic        respcyc_reg;
    logic [63:0] resp_data_reg;

    logic [63:0] line_reg [8];
    logic        line_we;
    logic [2:0]  line_waddr;
    logic [63:0] line_wdata;

    logic        hit_done;
    logic        wb_done;
    logic        fill_start;
    logic        fill_done;

    logic [2:0]  word;
    logic        cmd_valid;
    logic        is_write;
    logic        hit;
    logic        unused_addr_bits;

    assign word             = req_addr[5:3];
    assign cmd_valid        = (req_cmd == CMD_READ) || (req_cmd == CMD_WRITE);
    assign is_write         = (req_cmd == CMD_WRITE);
    assign hit              = valid_reg && (tag_reg == req_addr[63:6]);
    assign unused_addr_bits = ^req_addr[2:0];

    // Line storage: one register per word, written by either a store hit or a fill beat.
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
        logic [63:0] word_reg;
        always_ff @(posedge clk) begin
            if (line_we && (line_waddr == 3'(gi))) begin
                word_reg <= line_wdata;
            end
        end
        assign line_reg[gi] = word_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            beat_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        dbus_reqcyc  = 1'b0;
        dbus_req     = 64'd0;
        dbus_reqtag  = 13'd0;
        dbus_respack = 1'b0;
        line_we      = 1'b0;
        line_waddr   = beat_reg;
        line_wdata   = dbus_resp;
        hit_done     = 1'b0;
        wb_done      = 1'b0;
        fill_start   = 1'b0;
        fill_done    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (hit) begin
                        hit_done   = 1'b1;
                        line_we    = is_write;
                        line_waddr = word;
                        line_wdata = req_data;
                        state_next = HIT_RESP;
                    end else if (dirty_reg) begin
                        state_next = WB_ADDR;
                    end else begin
                        state_next = FILL_ADDR;
                    end
                end
            end
            // The requester still presents the finished command here; let it drop.
            HIT_RESP: begin
                state_next = IDLE;
            end
            WB_ADDR: begin
                dbus_reqcyc = 1'b1;
                dbus_req    = {tag_reg, 6'b0};
                dbus_reqtag = TAG_WR;
                if (dbus_reqack) begin
                    beat_next  = 3'd0;
                    state_next = WB_DATA;
                end
            end
            WB_DATA: begin
                dbus_reqcyc = 1'b1;
                dbus_req    = line_reg[beat_reg];
                dbus_reqtag = TAG_WR;
                if (dbus_reqack) begin
                    beat_next = beat_reg + 3'd1;
                    if (beat_reg == 3'd7) begin
                        wb_done    = 1'b1;
                        state_next = FILL_ADDR;
                    end
                end
            end
            FILL_ADDR: begin
                dbus_reqcyc = 1'b1;
                dbus_req    = {req_addr[63:6], 6'b0};
                dbus_reqtag = TAG_RD;
                if (dbus_reqack) begin
                    fill_start = 1'b1;
                    beat_next  = 3'd0;
                    state_next = FILL_DATA;
                end
            end
            FILL_DATA: begin
                dbus_respack = dbus_respcyc;
                if (dbus_respcyc) begin
                    line_we   = 1'b1;
                    beat_next = beat_reg + 3'd1;
                    if (beat_reg == 3'd7) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_reg       <= 58'd0;
            valid_reg     <= 1'b0;
            dirty_reg     <= 1'b0;
            respcyc_reg   <= 1'b0;
            resp_data_reg <= 64'd0;
        end else begin
            respcyc_reg <= hit_done;
            if (hit_done) begin
                resp_data_reg <= is_write ? req_data : line_reg[word];
                if (is_write) begin
                    dirty_reg <= 1'b1;
                end
            end
            if (wb_done) begin
                dirty_reg <= 1'b0;
            end
            // The line is partially overwritten during a fill, so it is not valid until beat 7.
            if (fill_start) begin
                valid_reg <= 1'b0;
            end
            if (fill_done) begin
                tag_reg   <= req_addr[63:6];
                valid_reg <= 1'b1;
                dirty_reg <= 1'b0;
            end
        end
    end

    assign respcyc   = respcyc_reg;
    assign resp_data = resp_data_reg;

endmodule

// File: tb/tb_line_d_cache.sv
// Directed bench for line_d_cache: a bus slave with a configurable ack delay and
// address-derived fill data, plus command sequences with hand-computed results.
module tb_line_d_cache;

    localparam logic [7:0] TID = 8'h5A;
    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dbus_reqcyc;
    logic [63:0] dbus_req;
    logic [12:0] dbus_reqtag;
    logic        dbus_reqack;
    logic        dbus_respcyc;
    logic [63:0] dbus_resp;
    logic        dbus_respack;
    logic [1:0]  req_cmd = 2'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_data = 64'd0;
    logic        respcyc;
    logic [63:0] resp_data;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave bookkeeping
    int          ack_delay = 0;
    int          stable_err = 0;
    int          fill_idx = -1;
    int          log_n = 0;
    logic [63:0] log_req [64];
    logic [12:0] log_tag [64];
    logic [63:0] s_req;
    logic [12:0] s_tag;

    line_d_cache #(.TAG_ID(TID)) dut (
        .clk          (clk),
        .reset        (reset),
        .dbus_reqcyc  (dbus_reqcyc),
        .dbus_req     (dbus_req),
        .dbus_reqtag  (dbus_reqtag),
        .dbus_reqack  (dbus_reqack),
        .dbus_respcyc (dbus_respcyc),
        .dbus_resp    (dbus_resp),
        .dbus_respack (dbus_respack),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .respcyc      (respcyc),
        .resp_data    (resp_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", name, got);
        end
    endtask

    task automatic do_cmd(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data,
                          output logic [63:0] got, output int lat);
        @(negedge clk);
        req_cmd  = cmd;
        req_addr = addr;
        req_data = data;
        lat = 0;
        got = 64'd0;
        forever begin
            @(negedge clk);
            lat++;
            if (respcyc) begin
                got = resp_data;
                break;
            end
            if (lat >= 400) begin
                check_val("cmd_done", {63'd0, respcyc}, 64'd1);
                break;
            end
        end
        req_cmd = NONE;
        $display("[TB] cmd=%0d addr=0x%0h data=0x%0h -> resp=0x%0h lat=%0d", cmd, addr, data, got, lat);
    endtask

    // Bus slave: acks each request beat after ack_delay cycles, answers reads with 8 beats.
    initial begin
        dbus_reqack  = 1'b0;
        dbus_respcyc = 1'b0;
        dbus_resp    = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && dbus_reqcyc) begin
                s_req = dbus_req;
                s_tag = dbus_reqtag;
                for (int k = 0; k < ack_delay; k++) begin
                    @(posedge clk);
                    #1;
                    if (!dbus_reqcyc || dbus_req !== s_req || dbus_reqtag !== s_tag) stable_err++;
                end
                dbus_reqack = 1'b1;
                @(posedge clk);
                #1;
                dbus_reqack = 1'b0;
                if (log_n < 64) begin
                    log_req[log_n] = s_req;
                    log_tag[log_n] = s_tag;
                end
                log_n++;
                if (s_tag[12]) begin
                    for (int i = 0; i < 8; i++) begin
                        if (reset) break;
                        fill_idx     = i;
                        dbus_respcyc = 1'b1;
                        dbus_resp    = ((s_req - 64'h1000) << 16) | (64'(i) * 64'h11);
                        @(posedge clk);
                        #1;
                    end
                    dbus_respcyc = 1'b0;
                    dbus_resp    = 64'd0;
                    fill_idx     = -1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        int lat;
        int base;
        int w;

        repeat (3) @(negedge clk);
        check_val("rst_reqcyc", {63'd0, dbus_reqcyc}, 64'd0);
        check_val("rst_respcyc", {63'd0, respcyc}, 64'd0);
        check_val("rst_resp_data", resp_data, 64'd0);
        check_val("rst_reqtag", {51'd0, dbus_reqtag}, 64'd0);
        reset = 1'b0;

        // Cold read: fill of 0x1000, word 1
        base = log_n;
        do_cmd(READ, 64'h1008, 64'd0, got, lat);
        check_val("cold_rd_data", got, 64'h11);
        check_val("cold_rd_beats", 64'(log_n - base), 64'd1);
        check_val("cold_fill_addr", log_req[base], 64'h1000);
        check_val("cold_fill_tag", {51'd0, log_tag[base]}, 64'h115A);

        // Hit read of the last word
        base = log_n;
        do_cmd(READ, 64'h1038, 64'd0, got, lat);
        check_val("hit_rd_data", got, 64'h77);
        check_val("hit_rd_lat", 64'(lat), 64'd1);
        check_val("hit_rd_nobus", 64'(log_n - base), 64'd0);

        // Store hit, then read it back
        base = log_n;
        do_cmd(WRITE, 64'h1010, 64'hDEAD, got, lat);
        check_val("wr_echo", got, 64'hDEAD);
        check_val("wr_lat", 64'(lat), 64'd1);
        do_cmd(READ, 64'h1017, 64'd0, got, lat);
        check_val("wr_readback", got, 64'hDEAD);
        check_val("wr_nobus", 64'(log_n - base), 64'd0);

        // Dirty miss with slow acks: writeback of 0x1000 then fill of 0x2000
        ack_delay = 3;
        base = log_n;
        do_cmd(READ, 64'h2000, 64'd0, got, lat);
        check_val("miss_rd_data", got, 64'h1000_0000);
        check_val("miss_beats", 64'(log_n - base), 64'd10);
        check_val("wb_addr", log_req[base], 64'h1000);
        check_val("wb_addr_tag", {51'd0, log_tag[base]}, 64'h015A);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("wb_beat%0d", i), log_req[base + 1 + i],
                      (i == 2) ? 64'hDEAD : 64'(i) * 64'h11);
        end
        check_val("wb_data_tag", {51'd0, log_tag[base + 5]}, 64'h015A);
        check_val("fill2_addr", log_req[base + 9], 64'h2000);
        check_val("fill2_tag", {51'd0, log_tag[base + 9]}, 64'h115A);
        check_val("req_stable", 64'(stable_err), 64'd0);

        do_cmd(READ, 64'h2038, 64'd0, got, lat);
        check_val("hit2_data", got, 64'h1000_0077);
        check_val("hit2_lat", 64'(lat), 64'd1);

        // Reset in the middle of fill beat 4
        ack_delay = 0;
        @(negedge clk);
        req_cmd  = READ;
        req_addr = 64'h1000;
        w = 0;
        while (fill_idx != 4 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_val("fill_at_beat4", 64'(fill_idx), 64'd4);
        reset = 1'b1;
        #1;
        check_val("mid_rst_reqcyc", {63'd0, dbus_reqcyc}, 64'd0);
        check_val("mid_rst_respack", {63'd0, dbus_respack}, 64'd0);
        check_val("mid_rst_respcyc", {63'd0, respcyc}, 64'd0);
        check_val("mid_rst_resp_data", resp_data, 64'd0);
        req_cmd = NONE;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        base = log_n;
        do_cmd(READ, 64'h1000, 64'd0, got, lat);
        check_val("post_rst_data", got, 64'h0);
        check_val("post_rst_beats", 64'(log_n - base), 64'd1);
        check_val("post_rst_fill_addr", log_req[base], 64'h1000);
        check_val("post_rst_fill_tag", {51'd0, log_tag[base]}, 64'h115A);
        do_cmd(READ, 64'h1028, 64'd0, got, lat);
        check_val("post_rst_hit", got, 64'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
